// File: rtl/ram_search_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_search_ctrl_if
// Purpose  : Command / response handshake bundle for ram_search_ctrl.
//            The master modport is the command issuer and response consumer.
//            The slave modport is the controller itself.
// Signals  : cmd_valid/cmd_ready/cmd_op/cmd_data  - command channel
//            rsp_valid/rsp_ready/rsp_found/rsp_index/rsp_err - response channel
// Revision : 1.0 - initial release
// ============================================================================
interface ram_search_ctrl_if #(
  parameter int DW = 8,
  parameter int AW = 4
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [DW-1:0] cmd_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_found;
  logic [AW-1:0] rsp_index;
  logic [1:0]    rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_found, rsp_index, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_found, rsp_index, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/ram_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ram_search_ctrl
// Purpose  : Command front-end for the RAM search stage. Accepts insert,
//            search and clear commands, sequences the add/start/clear strobes
//            of the search stage, waits on its rdy and returns a qualified
//            hit/index/error response.
// Ports    : clk        - clock, all state changes on posedge
//            reset_n    - asynchronous active-low reset
//            bus        - command/response handshake (slave side)
//            srch_add   - search stage add strobe
//            srch_start - search stage start strobe
//            srch_clr   - search stage synchronous clear strobe
//            srch_x     - search stage data / key
//            srch_rdy   - search stage done
//            srch_found - search stage match
//            count      - number of valid entries (0..2**AW)
// Revision : 1.0 - initial release
// ============================================================================
module ram_search_ctrl #(
  parameter int DW  = 8,
  parameter int AW  = 4,
  parameter int TMO = 20
) (
  input  logic               clk,
  input  logic               reset_n,
  ram_search_ctrl_if.slave   bus,
  output logic               srch_add,
  output logic               srch_start,
  output logic               srch_clr,
  output logic [DW-1:0]      srch_x,
  input  logic               srch_rdy,
  input  logic               srch_found,
  output logic [AW:0]        count
);

  localparam int            TW       = $clog2(TMO + 1);
  localparam logic [AW:0]   FULL     = (AW+1)'(2**AW);
  localparam logic [TW-1:0] TMO_LIM  = TW'(TMO);
  localparam logic [AW-1:0] IDX_MAX  = '1;

  localparam logic [1:0] OP_INS    = 2'b00;
  localparam logic [1:0] OP_SRCH   = 2'b01;
  localparam logic [1:0] OP_CLR    = 2'b10;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_FULL  = 2'b01;
  localparam logic [1:0] ERR_TMO   = 2'b10;
  localparam logic [1:0] ERR_BADOP = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INS    = 3'd1,
    S_CLR    = 3'd2,
    S_SSTART = 3'd3,
    S_SWAIT  = 3'd4,
    S_RESP   = 3'd5
  } state_t;

  state_t        r_state, w_state;
  logic          r_init;
  logic          r_cmd_ready, w_cmd_ready;
  logic          r_rsp_valid, w_rsp_valid;
  logic          r_rsp_found, w_rsp_found;
  logic [AW-1:0] r_rsp_index, w_rsp_index;
  logic [1:0]    r_rsp_err,   w_rsp_err;
  logic [AW-1:0] r_idx,       w_idx;
  logic [TW-1:0] r_tmo,       w_tmo;
  logic          w_add, w_start, w_clr;
  logic [DW-1:0] w_x;
  logic [AW:0]   w_count;

  // Strobes are registered on entry to INS/CLR/SSTART, so each is high for
  // exactly one full period and therefore straddles one negedge of the
  // search stage.
  always_comb begin
    w_state     = r_state;
    w_add       = 1'b0;
    w_start     = 1'b0;
    w_clr       = 1'b0;
    w_x         = srch_x;
    w_count     = count;
    w_idx       = r_idx;
    w_tmo       = r_tmo;
    w_rsp_valid = r_rsp_valid;
    w_rsp_found = r_rsp_found;
    w_rsp_index = r_rsp_index;
    w_rsp_err   = r_rsp_err;

    if (r_init) begin
      // First cycle after reset release: clear downstream pointers.
      w_clr   = 1'b1;
      w_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_cmd_ready && bus.cmd_valid) begin
            w_x         = bus.cmd_data;
            w_rsp_found = 1'b0;
            w_rsp_index = '0;
            w_rsp_err   = ERR_OK;
            case (bus.cmd_op)
              OP_INS: begin
                if (count == FULL) begin
                  w_rsp_err = ERR_FULL;
                  w_state   = S_RESP;
                end else begin
                  w_add   = 1'b1;
                  w_state = S_INS;
                end
              end
              OP_SRCH: begin
                if (count == '0) begin
                  w_state = S_RESP;
                end else begin
                  w_start = 1'b1;
                  w_state = S_SSTART;
                end
              end
              OP_CLR: begin
                w_clr   = 1'b1;
                w_state = S_CLR;
              end
              default: begin
                w_rsp_err = ERR_BADOP;
                w_state   = S_RESP;
              end
            endcase
          end
        end
        S_INS: begin
          w_count     = count + 1'b1;
          w_rsp_valid = 1'b1;
          w_state     = S_RESP;
        end
        S_CLR: begin
          w_count     = '0;
          w_rsp_valid = 1'b1;
          w_state     = S_RESP;
        end
        S_SSTART: begin
          // rdy seen here is left over from the previous search; ignore it.
          w_idx   = '0;
          w_tmo   = '0;
          w_state = S_SWAIT;
        end
        S_SWAIT: begin
          if (srch_rdy) begin
            w_rsp_valid = 1'b1;
            w_state     = S_RESP;
            // A hit at or beyond count is an unwritten slot holding old data.
            if (srch_found && ({1'b0, r_idx} < count)) begin
              w_rsp_found = 1'b1;
              w_rsp_index = r_idx;
            end else begin
              w_rsp_found = 1'b0;
              w_rsp_index = '0;
            end
          end else if (r_tmo == TMO_LIM) begin
            w_rsp_err   = ERR_TMO;
            w_rsp_valid = 1'b1;
            w_state     = S_RESP;
          end else begin
            // Track the downstream scan counter one slot per cycle.
            w_idx = (r_idx == IDX_MAX) ? r_idx : r_idx + 1'b1;
            w_tmo = r_tmo + 1'b1;
          end
        end
        S_RESP: begin
          // Paths that reach RESP straight from IDLE raise rsp_valid one
          // cycle later, keeping their latency equal to insert/clear.
          if (!r_rsp_valid) begin
            w_rsp_valid = 1'b1;
          end else if (bus.rsp_ready) begin
            w_rsp_valid = 1'b0;
            w_state     = S_IDLE;
          end
        end
        default: begin
          w_state = S_IDLE;
        end
      endcase
    end

    w_cmd_ready = (w_state == S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_init      <= 1'b1;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_found <= 1'b0;
      r_rsp_index <= '0;
      r_rsp_err   <= '0;
      r_idx       <= '0;
      r_tmo       <= '0;
      srch_add    <= 1'b0;
      srch_start  <= 1'b0;
      srch_clr    <= 1'b0;
      srch_x      <= '0;
      count       <= '0;
    end else begin
      r_init      <= 1'b0;
      r_cmd_ready <= w_cmd_ready;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_found <= w_rsp_found;
      r_rsp_index <= w_rsp_index;
      r_rsp_err   <= w_rsp_err;
      r_idx       <= w_idx;
      r_tmo       <= w_tmo;
      srch_add    <= w_add;
      srch_start  <= w_start;
      srch_clr    <= w_clr;
      srch_x      <= w_x;
      count       <= w_count;
    end
  end

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_found = r_rsp_found;
  assign bus.rsp_index = r_rsp_index;
  assign bus.rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_ram_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_search_ctrl
// Purpose  : Self-checking bench for ram_search_ctrl. A behavioural search
//            stage (negedge-updated table with write pointer and linear scan)
//            sits downstream; expected responses come from a queue holding
//            the valid entries.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_search_ctrl;
  localparam int DW  = 8;
  localparam int AW  = 4;
  localparam int TMO = 20;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          srch_add, srch_start, srch_clr, srch_rdy, srch_found;
  logic [DW-1:0] srch_x;
  logic [AW:0]   count;

  int checks = 0;
  int errors = 0;

  ram_search_ctrl_if #(.DW(DW), .AW(AW)) bus ();

  ram_search_ctrl #(.DW(DW), .AW(AW), .TMO(TMO)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .srch_add   (srch_add),
    .srch_start (srch_start),
    .srch_clr   (srch_clr),
    .srch_x     (srch_x),
    .srch_rdy   (srch_rdy),
    .srch_found (srch_found),
    .count      (count)
  );

  always #5 clk = ~clk;

  // Behavioural search stage: table contents survive a clear, only the
  // write pointer is reset, so old values linger past count.
  logic [DW-1:0] ds_mem [16];
  int  ds_wp = 0;
  int  ds_cnt = 0;
  bit  ds_scan = 0, ds_rdy = 0, ds_found = 0;
  bit  stall = 0;

  always @(negedge clk) begin
    if (srch_clr === 1'b1) begin
      ds_wp = 0; ds_scan = 0; ds_rdy = 0; ds_found = 0;
    end else if (srch_add === 1'b1) begin
      ds_mem[ds_wp] = srch_x;
      ds_wp = (ds_wp + 1) % 16;
    end else if (srch_start === 1'b1) begin
      ds_cnt = 0; ds_scan = 1; ds_rdy = 0; ds_found = 0;
    end else if (ds_scan) begin
      if (ds_mem[ds_cnt] == srch_x) begin
        ds_rdy = 1; ds_found = 1; ds_scan = 0;
      end else if (ds_cnt == 15) begin
        ds_rdy = 1; ds_found = 0; ds_scan = 0;
      end else begin
        ds_cnt++;
      end
    end
  end

  assign srch_rdy   = stall ? 1'b0 : ds_rdy;
  assign srch_found = ds_found;

  // Strobe high-cycle counters; a one-period pulse is seen at one negedge.
  int add_n = 0, start_n = 0, clr_n = 0;
  always @(negedge clk) begin
    if (srch_add   === 1'b1) add_n++;
    if (srch_start === 1'b1) start_n++;
    if (srch_clr   === 1'b1) clr_n++;
  end

  // Reference model: the valid entries in insertion order.
  logic [DW-1:0] q [$];

  logic          cap_f;
  logic [AW-1:0] cap_i;
  logic [1:0]    cap_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [DW-1:0] data);
    int n = 0;
    @(negedge clk);
    while (bus.cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_wait", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  // Latency counts cycles from the accept cycle to the first cycle with
  // rsp_valid high.
  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.rsp_valid !== 1'b1 && lat < 80);
    check("rsp_valid_wait", bus.rsp_valid, 1);
    cap_f = bus.rsp_found;
    cap_i = bus.rsp_index;
    cap_e = bus.rsp_err;
  endtask

  task automatic ack_rsp();
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    check("rsp_valid_drop", bus.rsp_valid, 0);
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [DW-1:0] data);
    logic          ef;
    logic [AW-1:0] ei;
    logic [1:0]    ee;
    int            el, ea, es, ec, a0, s0, c0, lat;
    string         tag;
    ef = 1'b0; ei = '0; ee = 2'b00; el = 2; ea = 0; es = 0; ec = 0;
    case (op)
      2'b00: begin
        if (q.size() == 16) ee = 2'b01;
        else begin q.push_back(data); ea = 1; end
      end
      2'b01: begin
        if (q.size() != 0) begin
          es = 1;
          if (stall) begin
            ee = 2'b10; el = TMO + 3;
          end else begin
            el = -1;
            foreach (q[i]) if (q[i] == data && !ef) begin
              ef = 1'b1; ei = AW'(i); el = i + 3;
            end
          end
        end
      end
      2'b10: begin q.delete(); ec = 1; end
      default: ee = 2'b11;
    endcase
    a0 = add_n; s0 = start_n; c0 = clr_n;
    tag = $sformatf("op%0d_%02h", op, data);
    issue(op, data);
    wait_rsp(lat);
    check({tag, "_found"}, cap_f, ef);
    check({tag, "_index"}, cap_i, ei);
    check({tag, "_err"}, cap_e, ee);
    if (el >= 0) check({tag, "_latency"}, lat, el);
    ack_rsp();
    check({tag, "_add_pulses"}, add_n - a0, ea);
    check({tag, "_start_pulses"}, start_n - s0, es);
    check({tag, "_clr_pulses"}, clr_n - c0, ec);
    check({tag, "_count"}, count, q.size());
  endtask

  initial begin
    int c0, a0;
    logic [DW-1:0] v;
    reset_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_data = '0; bus.rsp_ready = 1'b0;
    for (int i = 0; i < 16; i++) ds_mem[i] = '0;

    // Reset state and release
    repeat (3) @(negedge clk);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_strobes", {srch_add, srch_start, srch_clr}, 0);
    check("rst_count", count, 0);
    check("rst_srch_x", srch_x, 0);
    c0 = clr_n;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rel_clr_pulses", clr_n - c0, 1);
    check("rel_cmd_ready", bus.cmd_ready, 1);
    check("rel_count", count, 0);
    check("rel_rsp_valid", bus.rsp_valid, 0);

    // Basic inserts and hit at slot 2 (latency 5)
    run_cmd(2'b00, 8'h11);
    run_cmd(2'b00, 8'h22);
    run_cmd(2'b00, 8'h33);
    run_cmd(2'b01, 8'h33);
    // Miss, then empty-table search after clear
    run_cmd(2'b01, 8'h44);
    run_cmd(2'b10, 8'h00);
    run_cmd(2'b01, 8'h55);

    // Stale slot: 0x77 left at slot 3 by an earlier fill
    for (int i = 0; i < 3; i++) run_cmd(2'b00, 8'($urandom_range(0, 8'h70)));
    run_cmd(2'b00, 8'h77);
    run_cmd(2'b10, 8'h00);
    for (int i = 0; i < 3; i++) run_cmd(2'b00, 8'($urandom_range(0, 8'h70)));
    run_cmd(2'b01, 8'h77);

    // Fill to 16 with distinct values, reject the 17th, find slot 15
    run_cmd(2'b10, 8'h00);
    for (int i = 0; i < 16; i++) run_cmd(2'b00, 8'((i << 4) | $urandom_range(0, 15)));
    run_cmd(2'b00, 8'hEE);
    v = q[15];
    run_cmd(2'b01, v);

    // Randomised command mix
    for (int n = 0; n < 40; n++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 4) run_cmd(2'b00, 8'($urandom));
      else if (sel < 8) begin
        if (q.size() != 0 && $urandom_range(0, 1) == 1) v = q[$urandom_range(0, q.size() - 1)];
        else v = 8'($urandom);
        run_cmd(2'b01, v);
      end
      else if (sel == 8) run_cmd(2'b10, 8'($urandom));
      else run_cmd(2'b11, 8'($urandom));
    end

    // Response back-pressure: fields hold, no new command taken
    run_cmd(2'b10, 8'h00);
    q.push_back(8'h5A);
    issue(2'b00, 8'h5A);
    begin
      int lat;
      wait_rsp(lat);
    end
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'b00; bus.cmd_data = 8'hA5;
    a0 = add_n;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", bus.rsp_valid, 1);
      check("hold_fields", {bus.rsp_found, bus.rsp_index, bus.rsp_err}, {cap_f, cap_i, cap_e});
      check("hold_cmd_ready", bus.cmd_ready, 0);
    end
    bus.cmd_valid = 1'b0;
    ack_rsp();
    check("hold_add_pulses", add_n - a0, 0);
    check("hold_count", count, q.size());

    // Reset during SWAIT aborts without a response
    stall = 1;
    issue(2'b01, 8'h5A);
    repeat (4) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("abort_rsp_valid", bus.rsp_valid, 0);
    check("abort_start", srch_start, 0);
    check("abort_count", count, 0);
    q.delete();
    stall = 0;
    @(negedge clk);
    c0 = clr_n;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_no_rsp", bus.rsp_valid, 0);
    end
    check("abort_clr_pulses", clr_n - c0, 1);
    check("abort_cmd_ready", bus.cmd_ready, 1);

    // Timeout when rdy never rises
    run_cmd(2'b00, 8'h42);
    stall = 1;
    run_cmd(2'b01, 8'h42);
    stall = 0;
    run_cmd(2'b01, 8'h42);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global guard so the run always ends on its own
  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
`default_nettype wire
